taylor_exp_seq: RTL and testbench
=================================

# taylor_exp_seq

Iterative single-precision e^x evaluator: a parametrised successor to the fixed ten-term unrolled Taylor expansion. It reuses one term-update datapath over N_TERMS cycles instead of instantiating one multiplier, divider and adder per term. Operands arrive and leave through valid/ready handshakes, and special IEEE-754 inputs are bypassed. It sits in the nroot/TAYLOR datapath and feeds the nroot and exponent users.

## Interface
- `N_TERMS`, 10: highest Taylor power evaluated; legal range 2..12 (elaboration error outside).
- `EARLY_EXIT`, 1: when 1, iteration stops as soon as a term can no longer change the sum.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operand `in` is valid.
- `in_ready`  out  1: block can accept an operand (high only in IDLE).
- `in`  in  32: IEEE-754 single-precision x.
- `out_valid`  out  1: `out` holds a finished result.
- `out_ready`  in  1: consumer takes the result.
- `out`  out  32: IEEE-754 single-precision e^x.
- `n_used`  out  4: number of terms actually accumulated for the current result (1..N_TERMS).

## Operation
- States: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, the block latches x_q=in, term_q=1.0 (32'h3F800000), sum_q=1.0 and k=1.
  - Normal input: go to ITER.
  - Special input (exponent field 8'hFF): load the result directly and go to DONE. NaN gives 32'h7FC00000, +inf gives 32'h7F800000, -inf gives 32'h00000000. n_used=0.
- ITER, one term per cycle:
  - term_next = mult(mult(term_q, x_q), INV_K[k]).
  - sum_q <= add_sub(sum_q, term_next, checkequation=0).
  - term_q <= term_next.
  - n_used <= k.
  - k <= k+1.
- Exit ITER to DONE when any of these holds:
  - k==N_TERMS.
  - EARLY_EXIT=1 and the term_next exponent field is 0 (the term is zero or subnormal).
  - EARLY_EXIT=1 and the exponent field of sum_q exceeds that of term_next by more than 24.
- Both early-exit conditions are evaluated on the term being added in that cycle; that term is still accumulated.
- DONE:
  - out_valid=1, out=sum_q.
  - On out_ready: go to IDLE.
  - Without out_ready: out and n_used hold stable.
- Arithmetic: all values are fp32 via the existing mult/add_sub units, so rounding and overflow behaviour is theirs. An overflowing sum propagates whatever add_sub produces, with no saturation.
- Reset (any state, asynchronous): state=IDLE, in_ready=1 after release, out_valid=0, out=32'h0, n_used=0, k=1, internal registers cleared. An in-flight operation is discarded without a result.

## Timing
- Normal operand accepted at edge E0: ITER occupies edges E1..En, with n = N_TERMS or fewer on early exit. out_valid is high in the cycle after En.
- Full latency: N_TERMS+1 edges from the accepting edge to out_valid (11 at default).
- Special input: out_valid is high in the cycle after the accepting edge.
- Throughput: one operation in flight; in_ready stays 0 from acceptance until the result handshake completes.
- in_ready rises the cycle after the out_valid&&out_ready edge, so there is no same-cycle accept in DONE.
- The critical path is two mult plus one add_sub per cycle.

## Structure
- Package `taylor_pkg`:
  - `state_t` enum {IDLE, ITER, DONE}.
  - FP_ONE=32'h3F800000, FP_QNAN=32'h7FC00000, FP_PINF=32'h7F800000.
  - INV_K[1..12], the fp32 constants for 1/k: 1/1=32'h3F800000, 1/2=32'h3F000000, 1/3=32'h3EAAAAAB, and so on through 1/12.
  - EXIT_GAP=24.
- Sub-module `taylor_term_step`: combinational, wrapping the two mult instances and the add_sub. Inputs are term, x, inv_k and sum; outputs are term_next and sum_next. The FSM lives in `taylor_exp_seq`.

## Test plan
- in=32'h3F800000 (1.0), EARLY_EXIT=0, N_TERMS=10 -> out_valid exactly 11 edges after accept; out within ±4 ULP of 32'h402DF854; n_used=10.
- in=32'hBF800000 (-1.0) -> out within ±4 ULP of 32'h3EBC5AB2.
- in=32'h00000000, EARLY_EXIT=1 -> exit after the first ITER cycle; out=32'h3F800000; n_used=1; out_valid 2 edges after accept.
- Specials: in=32'h7FC00001 -> out=32'h7FC00000; in=32'hFF800000 -> out=32'h0; in=32'h7F800000 -> out=32'h7F800000. Each has out_valid 1 edge after accept and n_used=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out, n_used and out_valid are stable and in_ready=0. After out_ready=1, in_ready=1 the next cycle and a back-to-back second operand is accepted.
- Assert rst_n=0 asynchronously mid-ITER (k=5) -> out_valid=0 and n_used=0 immediately. After release, in_ready=1, and a fresh in=1.0 produces the correct result.

Source files
------------

// File: rtl/taylor_pkg.sv
// Shared constants, state encoding and the fp32 mult / add_sub units for the Taylor e^x evaluator.
// Subnormal operands and results are flushed to zero; rounding is round-to-nearest-even.
package taylor_pkg;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP_PINF = 32'h7F800000;
    localparam int unsigned EXIT_GAP = 24;

    function automatic logic [31:0] inv_k(input logic [3:0] k);
        case (k)
            4'd1:    return 32'h3F800000;
            4'd2:    return 32'h3F000000;
            4'd3:    return 32'h3EAAAAAB;
            4'd4:    return 32'h3E800000;
            4'd5:    return 32'h3E4CCCCD;
            4'd6:    return 32'h3E2AAAAB;
            4'd7:    return 32'h3E124925;
            4'd8:    return 32'h3E000000;
            4'd9:    return 32'h3DE38E39;
            4'd10:   return 32'h3DCCCCCD;
            4'd11:   return 32'h3DBA2E8C;
            4'd12:   return 32'h3DAAAAAB;
            default: return FP_ONE;
        endcase
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [23:0] m;
        logic        g;
        logic        st;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            // inf * 0 and any NaN operand give the canonical quiet NaN
            if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0)
                || a[30:23] == 8'h00 || b[30:23] == 8'h00)
                return FP_QNAN;
            return {s, 8'hFF, 23'h0};
        end
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m  = {1'b0, p[46:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 1;
        end else begin
            m  = {1'b0, p[45:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) e = e + 1;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add_sub(input logic [31:0] a, input logic [31:0] b,
                                                input logic sub);
        logic [31:0] bb;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  d;
        logic [26:0] mh;
        logic [26:0] ml;
        logic [27:0] r;
        logic [23:0] m;
        logic        g;
        logic        st;
        int          e;
        bb = {b[31] ^ sub, b[30:0]};
        if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (bb[30:23] == 8'hFF && bb[22:0] != 23'h0))
            return FP_QNAN;
        if (a[30:23] == 8'hFF) return (bb[30:23] == 8'hFF && bb[31] != a[31]) ? FP_QNAN : a;
        if (bb[30:23] == 8'hFF) return bb;
        if (a[30:23] == 8'h00) return (bb[30:23] == 8'h00) ? 32'h0 : bb;
        if (bb[30:23] == 8'h00) return a;
        if (bb[30:0] > a[30:0]) begin
            hi = bb;
            lo = a;
        end else begin
            hi = a;
            lo = bb;
        end
        d  = hi[30:23] - lo[30:23];
        mh = {1'b1, hi[22:0], 3'b000};
        ml = {1'b1, lo[22:0], 3'b000};
        // Alignment keeps a sticky bit in the LSB so rounding sees shifted-out ones
        if (d > 8'd26) begin
            ml = 27'h1;
        end else begin
            st = |(ml & ((27'h1 << d) - 27'h1));
            ml = (ml >> d) | {26'h0, st};
        end
        e = int'(hi[30:23]);
        if (hi[31] == lo[31]) begin
            r = {1'b0, mh} + {1'b0, ml};
            if (r[27]) begin
                r = {1'b0, r[27:2], r[1] | r[0]};
                e = e + 1;
            end
        end else begin
            r = {1'b0, mh - ml};
            if (r == 28'h0) return 32'h0;
            for (int i = 0; i < 26; i++) begin
                if (!r[26]) begin
                    r = r << 1;
                    e = e - 1;
                end
            end
        end
        m  = {1'b0, r[25:3]};
        g  = r[2];
        st = r[1] | r[0];
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) e = e + 1;
        if (e >= 255) return {hi[31], 8'hFF, 23'h0};
        if (e <= 0) return {hi[31], 31'h0};
        return {hi[31], e[7:0], m[22:0]};
    endfunction

endpackage

// File: rtl/taylor_exp_seq_term_step.sv
// Combinational term update: term_next = term * x * (1/k), sum_next = sum + term_next.
module taylor_term_step
    import taylor_pkg::*;
(
    input  logic [31:0] term,
    input  logic [31:0] x,
    input  logic [31:0] inv_k,
    input  logic [31:0] sum,
    output logic [31:0] term_next,
    output logic [31:0] sum_next
);

    logic [31:0] term_x;

    always_comb begin
        term_x    = fp_mul(term, x);
        term_next = fp_mul(term_x, inv_k);
        sum_next  = fp_add_sub(sum, term_next, 1'b0);
    end

endmodule

// File: rtl/taylor_exp_seq.sv
// Iterative fp32 e^x: one Taylor term per cycle through a shared step datapath,
// valid/ready on both sides, IEEE special inputs bypassed straight to DONE.
module taylor_exp_seq
    import taylor_pkg::*;
#(
    parameter int N_TERMS    = 10,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [3:0]  n_used
);

    if (N_TERMS < 2 || N_TERMS > 12) begin : g_bad_n_terms
        $error("taylor_exp_seq: N_TERMS must be in 2..12");
    end

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] term_q, term_d;
    logic [31:0] sum_q, sum_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  n_used_q, n_used_d;

    logic [31:0] term_next;
    logic [31:0] sum_next;
    logic        exit_iter;

    taylor_term_step u_step (
        .term      (term_q),
        .x         (x_q),
        .inv_k     (inv_k(k_q)),
        .sum       (sum_q),
        .term_next (term_next),
        .sum_next  (sum_next)
    );

    // Early exit looks at the term being added now; that term is still accumulated.
    always_comb begin
        exit_iter = (k_q == 4'(N_TERMS));
        if (EARLY_EXIT) begin
            if (term_next[30:23] == 8'h00) exit_iter = 1'b1;
            if ({1'b0, sum_q[30:23]} > ({1'b0, term_next[30:23]} + 9'(EXIT_GAP))) exit_iter = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        term_d   = term_q;
        sum_d    = sum_q;
        k_d      = k_q;
        n_used_d = n_used_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = in;
                    term_d   = FP_ONE;
                    sum_d    = FP_ONE;
                    k_d      = 4'd1;
                    n_used_d = 4'd0;
                    if (in[30:23] == 8'hFF) begin
                        if (in[22:0] != 23'h0) sum_d = FP_QNAN;
                        else if (in[31])       sum_d = 32'h0;
                        else                   sum_d = FP_PINF;
                        state_d = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                term_d   = term_next;
                sum_d    = sum_next;
                n_used_d = k_q;
                k_d      = k_q + 4'd1;
                if (exit_iter) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= 32'h0;
            term_q   <= 32'h0;
            sum_q    <= 32'h0;
            k_q      <= 4'd1;
            n_used_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            term_q   <= term_d;
            sum_q    <= sum_d;
            k_q      <= k_d;
            n_used_q <= n_used_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = (state_q == DONE) ? sum_q : 32'h0;
    assign n_used    = n_used_q;

endmodule

// File: tb/tb_taylor_exp_seq.sv
// Scoreboard bench: instance 0 runs without early exit, instance 1 with it.
module tb_taylor_exp_seq;

    typedef struct {
        logic [31:0] val;
        int unsigned tol;
        logic [3:0]  n;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_a [2];
    logic        in_ready_a [2];
    logic [31:0] din        [2];
    logic        out_valid_a[2];
    logic        out_ready_a[2];
    logic [31:0] dout       [2];
    logic [3:0]  n_used_a   [2];

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    taylor_exp_seq #(.N_TERMS(10), .EARLY_EXIT(1'b0)) u_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a[0]),
        .in_ready  (in_ready_a[0]),
        .in        (din[0]),
        .out_valid (out_valid_a[0]),
        .out_ready (out_ready_a[0]),
        .out       (dout[0]),
        .n_used    (n_used_a[0])
    );

    taylor_exp_seq #(.N_TERMS(10), .EARLY_EXIT(1'b1)) u_early (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a[1]),
        .in_ready  (in_ready_a[1]),
        .in        (din[1]),
        .out_valid (out_valid_a[1]),
        .out_ready (out_ready_a[1]),
        .out       (dout[1]),
        .n_used    (n_used_a[1])
    );

    // Positive fp32 patterns are monotonic as integers, so ULP distance is a plain difference.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                         input int unsigned tol = 0);
        logic [31:0] d;
        total++;
        d = (obs > exp) ? obs - exp : exp - obs;
        if ($isunknown(obs) || d > tol) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic run_op(input int s, input logic [31:0] x, input logic [31:0] val,
                          input int unsigned tol, input logic [3:0] n, input int lat,
                          input int hold);
        exp_t        e;
        int          edges;
        logic [31:0] out_snap;
        logic [3:0]  n_snap;
        sb.push_back('{val: val, tol: tol, n: n, lat: lat});
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready_a[s]), 32'd1);
        din[s]        = x;
        in_valid_a[s] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[s] = 1'b0;
        edges = 1;
        check("in_ready_busy", 32'(in_ready_a[s]), 32'd0);
        while (!out_valid_a[s] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        e = sb.pop_front();
        check("out_valid", 32'(out_valid_a[s]), 32'd1);
        check("latency", 32'(edges), 32'(e.lat));
        check("out", dout[s], e.val, e.tol);
        check("n_used", 32'(n_used_a[s]), 32'(e.n));
        out_snap = dout[s];
        n_snap   = n_used_a[s];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out", dout[s], out_snap);
            check("hold_n_used", 32'(n_used_a[s]), 32'(n_snap));
            check("hold_valid", 32'(out_valid_a[s]), 32'd1);
            check("hold_in_ready", 32'(in_ready_a[s]), 32'd0);
        end
        @(negedge clk);
        out_ready_a[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[s] = 1'b0;
        check("in_ready_after", 32'(in_ready_a[s]), 32'd1);
        check("out_valid_clr", 32'(out_valid_a[s]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid_a[i]  = 1'b0;
            din[i]         = 32'h0;
            out_ready_a[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out_valid", 32'(out_valid_a[i]), 32'd0);
            check("rst_out", dout[i], 32'h0);
            check("rst_n_used", 32'(n_used_a[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready_a[0]), 32'd1);

        // Full ten-term runs: e^1 and e^-1
        run_op(0, 32'h3F800000, 32'h402DF854, 4, 4'd10, 11, 0);
        run_op(0, 32'hBF800000, 32'h3EBC5AB2, 4, 4'd10, 11, 0);

        // Early exit on a zero term, then specials
        run_op(1, 32'h00000000, 32'h3F800000, 0, 4'd1, 2, 0);
        run_op(1, 32'h7FC00001, 32'h7FC00000, 0, 4'd0, 1, 0);
        run_op(1, 32'hFF800000, 32'h00000000, 0, 4'd0, 1, 0);
        run_op(1, 32'h7F800000, 32'h7F800000, 0, 4'd0, 1, 0);

        // Backpressure, then a back-to-back operand
        run_op(1, 32'h3F800000, 32'h402DF854, 4, 4'd10, 11, 5);
        run_op(1, 32'h00000000, 32'h3F800000, 0, 4'd1, 2, 0);

        // Asynchronous reset while iterating at k=5
        @(negedge clk);
        din[0]        = 32'h3F800000;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_n_used", 32'(n_used_a[0]), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid_a[0]), 32'd0);
        check("arst_n_used", 32'(n_used_a[0]), 32'd0);
        check("arst_out", dout[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready_a[0]), 32'd1);
        run_op(0, 32'h3F800000, 32'h402DF854, 4, 4'd10, 11, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
